// File: rtl/uart_cmd_framer.sv
// Host-side command framer: expands one accepted command into its byte sequence and
// serializes each byte as a UART frame (start, data LSB-first, optional parity, stop, gap).
module uart_cmd_framer #(
    parameter int unsigned width    = 8,
    parameter int unsigned PRESCALE = 8,
    parameter bit          PAR_EN   = 1'b1,
    parameter bit          PAR_TYP  = 1'b0,
    parameter int unsigned GAP_BITS = 0
) (
    input  logic             UART_CLK,
    input  logic             Reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [width-1:0] cmd_addr,
    input  logic [width-1:0] cmd_data_a,
    input  logic [width-1:0] cmd_data_b,
    input  logic [3:0]       cmd_fun,
    output logic             Tx_serial,
    output logic             busy,
    output logic             cmd_done
);

    localparam int unsigned PS_W  = $clog2(PRESCALE);
    localparam int unsigned IDX_W = (width > 1) ? $clog2(width) : 1;
    localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StGap} state_t;

    state_t                  r_state, w_state_d;
    logic [PS_W-1:0]         r_presc, w_presc_d;
    logic [IDX_W-1:0]        r_bit, w_bit_d;
    logic [GAP_W-1:0]        r_gap, w_gap_d;
    logic [1:0]              r_frame, w_frame_d;
    logic [1:0]              r_last, w_last_d;
    logic [3:0][width-1:0]   r_bytes, w_bytes_d;
    logic                    r_tx, w_tx_d;
    logic                    r_busy, w_busy_d;
    logic                    r_done, w_done_d;
    logic                    w_bit_end;
    logic                    w_end_frame;
    logic [width-1:0]        w_byte;

    always_comb begin
        w_state_d   = r_state;
        w_presc_d   = r_presc;
        w_bit_d     = r_bit;
        w_gap_d     = r_gap;
        w_frame_d   = r_frame;
        w_last_d    = r_last;
        w_bytes_d   = r_bytes;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_end_frame = 1'b0;
        w_bit_end   = (r_presc == PS_W'(PRESCALE - 1));

        case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_state_d = StStart;
                    w_presc_d = '0;
                    w_bit_d   = '0;
                    w_gap_d   = '0;
                    w_frame_d = '0;
                    w_busy_d  = 1'b1;
                    // Byte 0 is the command byte; r_last holds the index of the final frame.
                    case (cmd_type)
                        2'd0: begin
                            w_bytes_d = {width'(0), cmd_data_a, cmd_addr, width'(8'hAA)};
                            w_last_d  = 2'd2;
                        end
                        2'd1: begin
                            w_bytes_d = {width'(0), width'(0), cmd_addr, width'(8'hBB)};
                            w_last_d  = 2'd1;
                        end
                        2'd2: begin
                            w_bytes_d = {width'(cmd_fun), cmd_data_b, cmd_data_a, width'(8'hCC)};
                            w_last_d  = 2'd3;
                        end
                        default: begin
                            w_bytes_d = {width'(0), width'(0), width'(cmd_fun), width'(8'hDD)};
                            w_last_d  = 2'd1;
                        end
                    endcase
                end
            end
            default: begin
                if (!w_bit_end) begin
                    w_presc_d = r_presc + 1'b1;
                end else begin
                    w_presc_d = '0;
                    case (r_state)
                        StStart:  w_state_d = StData;
                        StData: begin
                            if (r_bit == IDX_W'(width - 1)) begin
                                w_bit_d   = '0;
                                w_state_d = PAR_EN ? StParity : StStop;
                            end else begin
                                w_bit_d = r_bit + 1'b1;
                            end
                        end
                        StParity: w_state_d = StStop;
                        StStop: begin
                            if (GAP_BITS == 0) w_end_frame = 1'b1;
                            else               w_state_d   = StGap;
                        end
                        StGap: begin
                            if (r_gap == GAP_W'(GAP_BITS - 1)) begin
                                w_gap_d     = '0;
                                w_end_frame = 1'b1;
                            end else begin
                                w_gap_d = r_gap + 1'b1;
                            end
                        end
                        default: w_state_d = StIdle;
                    endcase
                end
            end
        endcase

        if (w_end_frame) begin
            if (r_frame == r_last) begin
                w_state_d = StIdle;
                w_frame_d = '0;
                w_busy_d  = 1'b0;
                w_done_d  = 1'b1;
            end else begin
                w_state_d = StStart;
                w_frame_d = r_frame + 1'b1;
            end
        end

        // Line level is computed from the next state so Tx_serial can be a plain register.
        w_byte = w_bytes_d[w_frame_d];
        case (w_state_d)
            StStart:  w_tx_d = 1'b0;
            StData:   w_tx_d = w_byte[w_bit_d];
            StParity: w_tx_d = (^w_byte) ^ PAR_TYP;
            default:  w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge UART_CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= StIdle;
            r_presc <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_frame <= '0;
            r_last  <= '0;
            r_bytes <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_presc <= w_presc_d;
            r_bit   <= w_bit_d;
            r_gap   <= w_gap_d;
            r_frame <= w_frame_d;
            r_last  <= w_last_d;
            r_bytes <= w_bytes_d;
            r_tx    <= w_tx_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    assign Tx_serial = r_tx;
    assign busy      = r_busy;
    assign cmd_ready = !r_busy;
    assign cmd_done  = r_done;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: expected line waveform built per command from the byte list and
// the frame format, compared cycle by cycle along with the handshake/status outputs.
module tb_uart_cmd_framer;

    localparam int unsigned W  = 8;
    localparam int unsigned P  = 8;
    localparam bit          PE = 1'b1;
    localparam bit          PT = 1'b0;
    localparam int unsigned GB = 0;

    typedef struct {
        logic [1:0] typ;
        logic [7:0] addr;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fun;
    } cmd_t;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_type;
    logic [W-1:0] cmd_addr;
    logic [W-1:0] cmd_data_a;
    logic [W-1:0] cmd_data_b;
    logic [3:0]   cmd_fun;
    logic         tx;
    logic         busy;
    logic         cmd_done;

    int checks = 0;
    int errors = 0;
    bit exp_bits[$];

    uart_cmd_framer #(
        .width   (W),
        .PRESCALE(P),
        .PAR_EN  (PE),
        .PAR_TYP (PT),
        .GAP_BITS(GB)
    ) dut (
        .UART_CLK  (clk),
        .Reset     (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_addr  (cmd_addr),
        .cmd_data_a(cmd_data_a),
        .cmd_data_b(cmd_data_b),
        .cmd_fun   (cmd_fun),
        .Tx_serial (tx),
        .busy      (busy),
        .cmd_done  (cmd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.typ  = 2'($urandom_range(0, 3));
        c.addr = 8'($urandom);
        c.a    = 8'($urandom);
        c.b    = 8'($urandom);
        c.fun  = 4'($urandom);
        return c;
    endfunction

    function automatic cmd_t mk_cmd(input logic [1:0] typ, input logic [7:0] addr,
                                    input logic [7:0] a, input logic [7:0] b,
                                    input logic [3:0] fun);
        cmd_t c;
        c.typ  = typ;
        c.addr = addr;
        c.a    = a;
        c.b    = b;
        c.fun  = fun;
        return c;
    endfunction

    task automatic drive(input cmd_t c, input logic v);
        cmd_valid  = v;
        cmd_type   = c.typ;
        cmd_addr   = c.addr;
        cmd_data_a = c.a;
        cmd_data_b = c.b;
        cmd_fun    = c.fun;
    endtask

    // Serial line as a list of bit periods: start, data LSB-first, parity, stop, gap.
    task automatic build_expect(input cmd_t c);
        logic [7:0] bytes[$];
        exp_bits.delete();
        case (c.typ)
            2'd0: begin bytes.push_back(8'hAA); bytes.push_back(c.addr); bytes.push_back(c.a); end
            2'd1: begin bytes.push_back(8'hBB); bytes.push_back(c.addr); end
            2'd2: begin
                bytes.push_back(8'hCC); bytes.push_back(c.a); bytes.push_back(c.b);
                bytes.push_back({4'h0, c.fun});
            end
            default: begin bytes.push_back(8'hDD); bytes.push_back({4'h0, c.fun}); end
        endcase
        foreach (bytes[i]) begin
            exp_bits.push_back(1'b0);
            for (int k = 0; k < 8; k++) exp_bits.push_back(bytes[i][k]);
            if (PE) exp_bits.push_back((^bytes[i]) ^ PT);
            exp_bits.push_back(1'b1);
            for (int g = 0; g < int'(GB); g++) exp_bits.push_back(1'b1);
        end
    endtask

    // Caller has driven c with cmd_valid=1 at a negedge; returns at the negedge of the done cycle.
    task automatic run_cmd(input cmd_t c, input bit has_next, input cmd_t nxt);
        int total;
        build_expect(c);
        total = exp_bits.size() * P;
        @(posedge clk);
        @(negedge clk);
        if (has_next) drive(nxt, 1'b1);
        else          drive(rand_cmd(), 1'b0);
        for (int cyc = 0; cyc < total; cyc++) begin
            check_eq($sformatf("tx c%0d", cyc), {31'd0, tx}, {31'd0, exp_bits[cyc / P]});
            check_eq($sformatf("busy/ready/done c%0d", cyc), {29'd0, busy, cmd_ready, cmd_done},
                     32'b100);
            if (!has_next && (cyc % P) == 3) drive(rand_cmd(), 1'b0);
            @(negedge clk);
        end
        check_eq("done cycle", {28'd0, busy, cmd_ready, cmd_done, tx}, 32'b0111);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_eq("idle", {28'd0, busy, cmd_ready, cmd_done, tx}, 32'b0101);
        end
    endtask

    initial begin
        cmd_t c1, c2, cur, nxt;
        int k;
        bit b2b;

        rst = 1'b1;
        drive(mk_cmd(2'd0, 8'h00, 8'h00, 8'h00, 4'h0), 1'b0);
        #1;
        check_eq("reset no edge", {28'd0, busy, cmd_ready, cmd_done, tx}, 32'b0101);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3);

        c1 = mk_cmd(2'd0, 8'h0A, 8'hFF, 8'h00, 4'h0);
        drive(c1, 1'b1);
        run_cmd(c1, 1'b0, c1);
        idle(2);

        c1 = mk_cmd(2'd2, 8'h00, 8'h08, 8'h80, 4'h2);
        drive(c1, 1'b1);
        run_cmd(c1, 1'b0, c1);
        idle(2);

        c1 = mk_cmd(2'd1, 8'h0A, 8'h00, 8'h00, 4'h0);
        c2 = mk_cmd(2'd3, 8'h00, 8'h00, 8'h00, 4'hB);
        drive(c1, 1'b1);
        run_cmd(c1, 1'b1, c2);
        run_cmd(c2, 1'b0, c2);
        idle(2);

        // Reset in the middle of frame 2's data bits.
        c1 = mk_cmd(2'd0, 8'h5C, 8'h3E, 8'h00, 4'h0);
        build_expect(c1);
        drive(c1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 2 * exp_bits.size() * P / 3 + 2 * P + 4;
        repeat (k) @(negedge clk);
        check_eq("tx before reset", {31'd0, tx}, {31'd0, exp_bits[k / P]});
        rst = 1'b1;
        #1;
        check_eq("mid-frame reset", {28'd0, busy, cmd_ready, cmd_done, tx}, 32'b0101);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(40);
        c1 = mk_cmd(2'd2, 8'h00, 8'hA5, 8'h3C, 4'h7);
        drive(c1, 1'b1);
        run_cmd(c1, 1'b0, c1);
        idle(2);

        cur = rand_cmd();
        drive(cur, 1'b1);
        for (int i = 0; i < 10; i++) begin
            b2b = (i < 9) && ($urandom_range(0, 1) == 1);
            nxt = rand_cmd();
            run_cmd(cur, b2b, nxt);
            if (!b2b) begin
                idle($urandom_range(1, 4));
                if (i < 9) drive(nxt, 1'b1);
            end
            cur = nxt;
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Synthesizable host-side command framer that drives the system's serial `Rx_IN` line. Accepts one command per valid/ready handshake (register write, register read, ALU with operation, ALU without operation), expands it into the system's command byte sequence, and serializes each byte as a UART frame (start, 8 data LSB-first, optional parity, stop) at a fixed prescale of the UART clock. Sits directly upstream of the UART receiver in SYS_TOP; used as the stimulus source in system benches and on-board self-test.

## Interface
- `width`, 8: data/address byte width
- `PRESCALE`, 8: clock cycles per serial bit (>=2)
- `PAR_EN`, 1: 1 = parity bit inserted after data
- `PAR_TYP`, 0: 0 = even, 1 = odd parity
- `GAP_BITS`, 0: idle (line high) bit periods inserted after every stop bit

- `UART_CLK`  input  1  block clock; serial bit timing derived from it
- `Reset`  input  1  asynchronous, active-high reset
- `cmd_valid`  input  1  command present
- `cmd_ready`  output  1  framer idle, can accept a command
- `cmd_type`  input  2  0 = write, 1 = read, 2 = ALU with op, 3 = ALU no-op
- `cmd_addr`  input  width  register address (write/read)
- `cmd_data_a`  input  width  write data / ALU operand A
- `cmd_data_b`  input  width  ALU operand B
- `cmd_fun`  input  4  ALU function (zero-extended to width)
- `Tx_serial`  output  1  serial line to SYS_TOP `Rx_IN`, idle high
- `busy`  output  1  high from acceptance until last frame (incl. gap) ends
- `cmd_done`  output  1  one-cycle pulse when a command's last frame ends

## Operation
- Handshake: command captured when `cmd_valid && cmd_ready` on a rising edge; all `cmd_*` fields latched then, later input changes ignored. `cmd_ready = !busy`.
- Frame sequences (command byte first):
  - write: 0xAA, addr, data_a (3 frames)
  - read: 0xBB, addr (2)
  - ALU with op: 0xCC, data_a, data_b, fun (4)
  - ALU no-op: 0xDD, fun (2)
- Frame: start (0), data bits LSB-first, parity (if `PAR_EN`) = XOR of data bits (even) or its inverse (odd), stop (1), then `GAP_BITS` idle periods.
- FSM: IDLE -> START -> DATA (width bits) -> PARITY (skipped if !PAR_EN) -> STOP -> GAP (skipped if GAP_BITS = 0) -> START of next frame, or IDLE after last frame.
- Counters: prescale count 0..PRESCALE-1, bit index 0..width-1, frame index 0..3; each state/bit held exactly PRESCALE cycles.
- Reset (any time, including mid-frame): state IDLE, `Tx_serial` = 1, `busy` = 0, `cmd_ready` = 1, `cmd_done` = 0, all counters 0; partially sent command discarded, no `cmd_done`.

## Timing
- Acceptance edge N: `busy` = 1 and `Tx_serial` = 0 (start) from edge N.
- Bit k of a frame (start = 0) occupies cycles N+k·PRESCALE … N+(k+1)·PRESCALE-1 relative to frame start.
- Frame length F = (1 + width + PAR_EN + 1 + GAP_BITS)·PRESCALE cycles; frames back-to-back, no extra cycles.
- Command of n frames: last line bit ends at cycle N+n·F-1; at edge N+n·F: `cmd_done` = 1 for one cycle, `busy` = 0, `cmd_ready` = 1, `Tx_serial` = 1.
- `cmd_valid` high in the `cmd_done` cycle is accepted on that edge's successor (next rising edge); minimum inter-command spacing 1 idle cycle.
- `Tx_serial` registered, glitch-free; no combinational path from inputs to `Tx_serial`.

## Test plan
- Reset: assert `Reset` with no clock edge -> `Tx_serial`=1, `cmd_ready`=1, `busy`=0 immediately; hold 2 cycles, release, line stays 1.
- Write, addr 0x0A, data 0xFF, PRESCALE 8, even parity -> line carries 0xAA (par 0), 0x0A (par 0), 0xFF (par 0); 3·88 = 264 cycles busy; `cmd_done` at cycle 264.
- ALU with op, A=8, B=128, fun=2 -> bytes 0xCC, 0x08 (par 1), 0x80 (par 1), 0x02 (par 1); 352 cycles; SYS_TOP receiver reports no parity/stop error.
- Read addr 0x0A then ALU no-op fun 0x0B, second `cmd_valid` held high throughout -> second command accepted exactly one cycle after first `cmd_done`; bytes 0xBB,0x0A,0xDD,0x0B.
- `cmd_fields` change while busy -> transmitted bytes match latched values; `cmd_ready` low throughout.
- Reset asserted mid-DATA of frame 2 -> line high same cycle, no `cmd_done`; next command after release framed correctly from start bit.
